univ_shift_reg: RTL and testbench

Parametrised universal register: the successor to the fixed 3-bit load/hold register. It supports parallel load, clear, and multi-bit shift and rotate operations, all issued through a valid/ready command handshake. Multi-bit shifts execute one bit per clock under a small FSM, with busy and done status. It sits in datapaths that need serialisation, alignment or bit-field manipulation.

---
 rtl/univ_shift_pkg.sv | 20 ++
 rtl/univ_shift_step.sv | 45 ++++
 rtl/univ_shift_reg.sv | 147 ++++++++++++++
 tb/tb_univ_shift_reg.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/univ_shift_pkg.sv
// Shared op-code and FSM state types for the universal shift register.
package univ_shift_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_SHL   = 3'b010,
        OP_SHR   = 3'b011,
        OP_ROL   = 3'b100,
        OP_ROR   = 3'b101,
        OP_ASR   = 3'b110,
        OP_CLEAR = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/univ_shift_step.sv
// Combinational single-bit shift/rotate step: next register value and the bit leaving it.
module univ_shift_step
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  op_e              op_i,
    input  logic             ser_in_i,
    output logic [WIDTH-1:0] q_o,
    output logic             bit_o
);

    always_comb begin
        q_o   = q_i;
        bit_o = 1'b0;
        case (op_i)
            OP_SHL: begin
                q_o   = {q_i[WIDTH-2:0], ser_in_i};
                bit_o = q_i[WIDTH-1];
            end
            OP_SHR: begin
                q_o   = {ser_in_i, q_i[WIDTH-1:1]};
                bit_o = q_i[0];
            end
            OP_ROL: begin
                q_o   = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                bit_o = q_i[WIDTH-1];
            end
            OP_ROR: begin
                q_o   = {q_i[0], q_i[WIDTH-1:1]};
                bit_o = q_i[0];
            end
            OP_ASR: begin
                q_o   = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
                bit_o = q_i[0];
            end
            default: begin
                q_o   = q_i;
                bit_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: load/clear/multi-bit shift and rotate behind a valid/ready handshake.
// Optional parity output enabled by defining UNIV_SHIFT_PARITY_EN.
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
`ifdef UNIV_SHIFT_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [CNT_W-1:0] WIDTH_AMT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_AMT   = CNT_W'(1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               ser_out_q, ser_out_d;
    logic               done_q, done_d;

    op_e                cmd_op_e;
    op_e                step_op;
    logic [CNT_W-1:0]   amt_clamped;
    logic [WIDTH-1:0]   step_q;
    logic               step_bit;

    assign cmd_op_e    = op_e'(cmd_op);
    assign step_op     = (state_q == ST_SHIFT) ? op_q : cmd_op_e;
    assign amt_clamped = (cmd_amt > WIDTH_AMT) ? WIDTH_AMT : cmd_amt;

    univ_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_i      (q_q),
        .op_i     (step_op),
        .ser_in_i (ser_in),
        .q_o      (step_q),
        .bit_o    (step_bit)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        q_d       = q_q;
        ser_out_d = ser_out_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op_e)
                        OP_NOP: done_d = 1'b1;
                        OP_LOAD: begin
                            q_d    = data_in;
                            done_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            q_d    = '0;
                            done_d = 1'b1;
                        end
                        default: begin
                            if (amt_clamped == '0) begin
                                done_d = 1'b1;
                            end else begin
                                // First step lands on the accept edge itself
                                q_d       = step_q;
                                ser_out_d = step_bit;
                                if (amt_clamped > ONE_AMT) begin
                                    state_d = ST_SHIFT;
                                    rem_d   = amt_clamped - ONE_AMT;
                                    op_d    = cmd_op_e;
                                end else begin
                                    done_d = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                q_d       = step_q;
                ser_out_d = step_bit;
                rem_d     = rem_q - ONE_AMT;
                if (rem_q <= ONE_AMT) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            rem_q     <= '0;
            q_q       <= '0;
            ser_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            q_q       <= q_d;
            ser_out_q <= ser_out_d;
            done_q    <= done_d;
        end
    end

`ifdef UNIV_SHIFT_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^q_d;
        end
    end

    assign parity = parity_q;
`endif

    assign q         = q_q;
    assign ser_out   = ser_out_q;
    assign done      = done_q;
    assign busy      = (state_q == ST_SHIFT);
    assign cmd_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus randomized commands against an arithmetic model.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
    localparam int M  = 1 << W;
    localparam int H  = M / 2;

    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, CLR = 3'd7;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_amt;
    logic [W-1:0]  data_in;
    logic          ser_in;
    logic [W-1:0]  q;
    logic          ser_out;
    logic          busy;
    logic          done;
`ifdef UNIV_SHIFT_PARITY_EN
    logic          parity;
`endif

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .data_in   (data_in),
        .ser_in    (ser_in),
        .q         (q),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
`ifdef UNIV_SHIFT_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: register value and last bit shifted out
    int m_q;
    int m_ser;

    function automatic int mstep(input logic [2:0] op, input int v, input int s);
        case (op)
            SHL:     return (v * 2 + s) % M;
            SHR:     return v / 2 + s * H;
            ROL:     return (v * 2) % M + v / H;
            ROR:     return v / 2 + (v % 2) * H;
            ASR:     return v / 2 + (v / H) * H;
            default: return v;
        endcase
    endfunction

    function automatic int mout(input logic [2:0] op, input int v);
        if (op == SHL || op == ROL) return v / H;
        return v % 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit exp_busy, input bit exp_done);
        chk({tag, "_q"},     32'(q),         32'(m_q));
        chk({tag, "_ser"},   32'(ser_out),   32'(m_ser));
        chk({tag, "_busy"},  32'(busy),      32'(exp_busy));
        chk({tag, "_done"},  32'(done),      32'(exp_done));
        chk({tag, "_ready"}, 32'(cmd_ready), 32'(!exp_busy));
`ifdef UNIV_SHIFT_PARITY_EN
        chk({tag, "_par"},   32'(parity),    32'(^(m_q[W-1:0])));
`endif
    endtask

    // Issues one command from a negedge and checks every cycle up to and including its done cycle.
    // keep=1 leaves cmd_valid high with a LOAD 0x11 pending while the command is busy.
    task automatic run_cmd(input logic [2:0] op, input int amt, input logic [W-1:0] din,
                           input bit rnd, input bit sfix, input bit keep, input string tag);
        int n, steps, last, s;
        n     = (amt > W) ? W : amt;
        steps = (op inside {SHL, SHR, ROL, ROR, ASR}) ? n : 0;
        last  = (steps > 0) ? steps : 1;
        for (int k = 0; k < 40 && !cmd_ready; k++) @(negedge clk);
        chk({tag, "_wait_ready"}, 32'(cmd_ready), 32'd1);
        s         = rnd ? int'($urandom % 2) : int'(sfix);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = CW'(amt);
        data_in   = din;
        ser_in    = s[0];
        for (int e = 1; e <= last; e++) begin
            @(posedge clk);
            if (steps > 0) begin
                m_ser = mout(op, m_q);
                m_q   = mstep(op, m_q, s);
            end else if (op == LOAD) begin
                m_q = int'(din);
            end else if (op == CLR) begin
                m_q = 0;
            end
            @(negedge clk);
            check_all(tag, e < last, e == last);
            if (e == 1) begin
                if (keep) begin
                    cmd_op  = LOAD;
                    data_in = 8'h11;
                    cmd_amt = '0;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            s      = rnd ? int'($urandom % 2) : int'(sfix);
            ser_in = s[0];
        end
    endtask

    task automatic idle_tick(input string tag);
        @(posedge clk);
        @(negedge clk);
        check_all(tag, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_amt   = '0;
        data_in   = '0;
        ser_in    = 1'b0;
        m_q       = 0;
        m_ser     = 0;

        repeat (2) @(negedge clk);
        check_all("in_reset", 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_all("after_reset", 1'b0, 1'b0);

        run_cmd(LOAD, 0, 8'hA5, 1'b0, 1'b0, 1'b0, "load_a5");
        chk("load_a5_val", 32'(q), 32'h0000_00A5);
        idle_tick("load_a5_idle");

        run_cmd(SHL, 3, 8'h00, 1'b0, 1'b1, 1'b0, "shl3");
        chk("shl3_val", 32'(q), 32'h0000_002F);
        chk("shl3_ser", 32'(ser_out), 32'd1);
        idle_tick("shl3_idle");

        run_cmd(LOAD, 0, 8'hA5, 1'b0, 1'b0, 1'b0, "reload_a5");
        run_cmd(ROR, 4, 8'h00, 1'b0, 1'b0, 1'b0, "ror4");
        chk("ror4_val", 32'(q), 32'h0000_005A);
        run_cmd(ROL, 12, 8'h00, 1'b0, 1'b0, 1'b0, "rol12");
        chk("rol12_val", 32'(q), 32'h0000_005A);
        idle_tick("rol12_idle");

        run_cmd(LOAD, 0, 8'h80, 1'b0, 1'b0, 1'b0, "load_80");
        run_cmd(ASR, 3, 8'h00, 1'b0, 1'b0, 1'b1, "asr3_held");
        chk("asr3_val", 32'(q), 32'h0000_00F0);
        run_cmd(LOAD, 0, 8'h11, 1'b0, 1'b0, 1'b0, "held_load");
        chk("held_load_val", 32'(q), 32'h0000_0011);
        idle_tick("held_idle");

        run_cmd(SHR, 8, 8'h00, 1'b0, 1'b1, 1'b0, "shr8_ones");
        chk("shr8_val", 32'(q), 32'h0000_00FF);
        run_cmd(SHL, 0, 8'h00, 1'b0, 1'b0, 1'b0, "shl0");
        chk("shl0_val", 32'(q), 32'h0000_00FF);

`ifdef UNIV_SHIFT_PARITY_EN
        run_cmd(LOAD, 0, 8'h07, 1'b0, 1'b0, 1'b0, "par_load07");
        chk("par_load07_bit", 32'(parity), 32'd1);
        run_cmd(CLR, 0, 8'h00, 1'b0, 1'b0, 1'b0, "par_clear");
        chk("par_clear_q", 32'(q), 32'd0);
        chk("par_clear_bit", 32'(parity), 32'd0);
`endif

        for (int i = 0; i < 60; i++) begin
            run_cmd(3'($urandom % 8), int'($urandom_range(0, 15)), W'($urandom),
                    1'b1, 1'b0, 1'b0, "rand");
            if ($urandom % 2) idle_tick("rand_idle");
        end

        // Reset asserted between clock edges while a long shift is running
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = SHL;
        cmd_amt   = CW'(8);
        data_in   = '0;
        ser_in    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        #1;
        m_q   = 0;
        m_ser = 0;
        chk("async_rst_q",     32'(q),         32'd0);
        chk("async_rst_busy",  32'(busy),      32'd0);
        chk("async_rst_done",  32'(done),      32'd0);
        chk("async_rst_ser",   32'(ser_out),   32'd0);
        chk("async_rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all("post_rst", 1'b0, 1'b0);
        run_cmd(LOAD, 0, 8'h3C, 1'b0, 1'b0, 1'b0, "post_rst_load");
        chk("post_rst_load_val", 32'(q), 32'h0000_003C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
